dct_col_stream_tx: RTL and testbench

Transmit side of the transpose stage in the 8×8 2D DCT datapath.
- Accepts one full column vector in parallel from the transpose buffer's unload port.
- Sends it out one coefficient per cycle on a valid/ready stream, with column and block boundary markers.
- Optionally rounds and saturates each coefficient to the narrower output width.
- Sits between the transpose buffer and the coefficient output/quantiser interface.

---
 rtl/dct_pkg.sv | 21 ++
 rtl/dct_col_stream_tx_if.sv | 27 ++
 rtl/dct_col_round.sv | 41 ++++
 rtl/dct_col_stream_tx.sv | 90 +++++++++
 tb/tb_dct_col_stream_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared types and helpers for the 8x8 DCT transpose-stage stream blocks.
package dct_pkg;

   localparam int unsigned N_DEF     = 8;
   localparam int unsigned WIDTH_DEF = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } state_e;

   // Saturation bounds of a signed ow-bit value, widened to 64 bits
   function automatic longint sat_max(input int unsigned ow);
      return (longint'(1) <<< (ow - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int unsigned ow);
      return -(longint'(1) <<< (ow - 1));
   endfunction

endpackage

// File: rtl/dct_col_stream_tx_if.sv
// Column-in / coefficient-stream-out bus of dct_col_stream_tx.
interface dct_col_stream_tx_if
   import dct_pkg::*;
#(
   parameter int unsigned N         = N_DEF,
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned OUT_WIDTH = 16
);
   logic [N*WIDTH-1:0]   col_data;
   logic                 col_valid;
   logic                 col_ready;
   logic [OUT_WIDTH-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic                 s_last_col;
   logic                 s_last_blk;

   modport master (
      output col_data, col_valid, s_ready,
      input  col_ready, s_data, s_valid, s_last_col, s_last_blk
   );

   modport slave (
      input  col_data, col_valid, s_ready,
      output col_ready, s_data, s_valid, s_last_col, s_last_blk
   );
endinterface

// File: rtl/dct_col_round.sv
// Coefficient narrowing: arithmetic shift by FRAC; with DCT_COLSTREAM_ROUND_EN
// defined, round half up and saturate, otherwise floor and keep the low bits.
module dct_col_round
   import dct_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned FRAC      = 8
) (
   input  logic [WIDTH-1:0]     din_i,
   output logic [OUT_WIDTH-1:0] dout_o
);

`ifdef DCT_COLSTREAM_ROUND_EN
   // One guard bit so adding the rounding constant cannot wrap
   localparam int unsigned XW = WIDTH + 1;
   localparam logic signed [XW-1:0] RND   = XW'((longint'(1) << FRAC) >> 1);
   localparam logic signed [XW-1:0] MAX_V = XW'(sat_max(OUT_WIDTH));
   localparam logic signed [XW-1:0] MIN_V = XW'(sat_min(OUT_WIDTH));

   logic signed [XW-1:0] sum_c;
   logic signed [XW-1:0] shf_c;

   always_comb begin
      sum_c = XW'($signed(din_i)) + RND;
      shf_c = sum_c >>> FRAC;
      if (shf_c > MAX_V) begin
         dout_o = OUT_WIDTH'(MAX_V);
      end else if (shf_c < MIN_V) begin
         dout_o = OUT_WIDTH'(MIN_V);
      end else begin
         dout_o = OUT_WIDTH'(shf_c);
      end
   end
`else
   always_comb begin
      dout_o = OUT_WIDTH'($signed(din_i) >>> FRAC);
   end
`endif

endmodule

// File: rtl/dct_col_stream_tx.sv
// Transpose-stage transmitter: captures a column in parallel and streams it one
// coefficient per cycle with column/block markers. Rounding: DCT_COLSTREAM_ROUND_EN.
module dct_col_stream_tx
   import dct_pkg::*;
#(
   parameter int unsigned N         = N_DEF,
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned FRAC      = 8
) (
   input logic                clk,
   input logic                rst,
   dct_col_stream_tx_if.slave bus
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [IW-1:0]           col_q, col_d;
   logic [N-1:0][WIDTH-1:0] hold_q, hold_d;

   logic s_valid_c, last_c, xfer_c, col_ready_c, accept_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         idx_q   <= '0;
         col_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         col_q   <= col_d;
         hold_q  <= hold_d;
      end
   end

   // A new column may load in the same cycle the last word of the old one leaves
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      col_d   = col_q;
      hold_d  = hold_q;

      s_valid_c   = (state_q == SEND);
      last_c      = (idx_q == LAST);
      xfer_c      = s_valid_c & bus.s_ready;
      col_ready_c = ~rst & ((state_q == EMPTY) | (xfer_c & last_c));
      accept_c    = bus.col_valid & col_ready_c;

      case (state_q)
         EMPTY: begin
            if (accept_c) state_d = SEND;
         end
         SEND: begin
            if (xfer_c) begin
               if (!last_c) begin
                  idx_d = idx_q + IW'(1);
               end else begin
                  col_d = (col_q == LAST) ? '0 : col_q + IW'(1);
                  if (!accept_c) state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase

      if (accept_c) begin
         hold_d = bus.col_data;
         idx_d  = '0;
      end
   end

   dct_col_round #(
      .WIDTH    (WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .FRAC     (FRAC)
   ) u_round (
      .din_i (hold_q[idx_q]),
      .dout_o(bus.s_data)
   );

   assign bus.col_ready  = col_ready_c;
   assign bus.s_valid    = s_valid_c;
   assign bus.s_last_col = s_valid_c & last_c;
   assign bus.s_last_blk = s_valid_c & last_c & (col_q == LAST);

endmodule

// File: tb/tb_dct_col_stream_tx.sv
// Self-checking bench for dct_col_stream_tx: two instances (FRAC=0/32-bit out and
// FRAC=8/16-bit out) share one stimulus and are checked against a queue model.
module tb_dct_col_stream_tx;

   localparam int N = 8;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] col_data;
   logic           col_valid;
   logic           s_ready;

   always #5 clk = ~clk;

   dct_col_stream_tx_if #(.N(N), .WIDTH(W), .OUT_WIDTH(32)) if0 ();
   dct_col_stream_tx_if #(.N(N), .WIDTH(W), .OUT_WIDTH(16)) if8 ();

   assign if0.col_data  = col_data;
   assign if0.col_valid = col_valid;
   assign if0.s_ready   = s_ready;
   assign if8.col_data  = col_data;
   assign if8.col_valid = col_valid;
   assign if8.s_ready   = s_ready;

   dct_col_stream_tx #(.N(N), .WIDTH(W), .OUT_WIDTH(32), .FRAC(0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave));
   dct_col_stream_tx #(.N(N), .WIDTH(W), .OUT_WIDTH(16), .FRAC(8)) u_dut8 (
      .clk(clk), .rst(rst), .bus(if8.slave));

   typedef struct {
      logic [31:0] din;
      longint      exp_rnd;
      longint      exp_flr;
   } vec_t;

   vec_t   tbl[8];
   longint pend[$];
   int     colcnt = 0;
   int     total = 0, bad = 0;
   int     nwords = 0, nblk = 0, blk_word = 0;

   logic           cur_r, cur_cv, cur_sr, cur_cr;
   logic [N*W-1:0] cur_cd;

   function automatic longint conv(input longint x, input int frac, input int ow);
      longint v, hi, lo;
`ifdef DCT_COLSTREAM_ROUND_EN
      if (frac > 0) x = x + (longint'(1) << (frac - 1));
      v  = x >>> frac;
      hi = (longint'(1) << (ow - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) v = hi;
      if (v < lo) v = lo;
`else
      v = x >>> frac;
      v = (v << (64 - ow)) >>> (64 - ow);
`endif
      return v;
   endfunction

   function automatic logic [N*W-1:0] rand_col();
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = $urandom;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, then check outputs against the model's view
   task automatic drive_check(input logic r, input logic cv, input logic [N*W-1:0] cd,
                              input logic sr);
      bit exp_sv, exp_lc, exp_lb, exp_cr;
      rst = r; col_valid = cv; col_data = cd; s_ready = sr;
      #1;
      exp_sv = (pend.size() != 0);
      exp_lc = (pend.size() == 1);
      exp_lb = exp_lc && (colcnt == N - 1);
      exp_cr = !r && (!exp_sv || (exp_lc && sr));
      chk("col_ready0", longint'(if0.col_ready), longint'(exp_cr));
      chk("col_ready8", longint'(if8.col_ready), longint'(exp_cr));
      chk("s_valid0", longint'(if0.s_valid), longint'(exp_sv));
      chk("s_valid8", longint'(if8.s_valid), longint'(exp_sv));
      chk("last_col0", longint'(if0.s_last_col), longint'(exp_lc));
      chk("last_col8", longint'(if8.s_last_col), longint'(exp_lc));
      chk("last_blk0", longint'(if0.s_last_blk), longint'(exp_lb));
      chk("last_blk8", longint'(if8.s_last_blk), longint'(exp_lb));
      if (exp_sv) begin
         chk("s_data0", longint'($signed(if0.s_data)), conv(pend[0], 0, 32));
         chk("s_data8", longint'($signed(if8.s_data)), conv(pend[0], 8, 16));
      end
      if (if8.s_valid && sr) begin
         nwords++;
         if (if8.s_last_blk) begin
            nblk++;
            blk_word = nwords;
         end
      end
      cur_r = r; cur_cv = cv; cur_cd = cd; cur_sr = sr; cur_cr = exp_cr;
   endtask

   task automatic advance();
      @(posedge clk);
      if (cur_r) begin
         pend.delete();
         colcnt = 0;
      end else begin
         if (pend.size() != 0 && cur_sr) begin
            if (pend.size() == 1) colcnt = (colcnt + 1) % N;
            void'(pend.pop_front());
         end
         if (cur_cv && cur_cr)
            for (int k = 0; k < N; k++) pend.push_back(longint'($signed(cur_cd[k*W +: W])));
      end
      #1;
   endtask

   task automatic cyc(input logic r, input logic cv, input logic [N*W-1:0] cd, input logic sr);
      drive_check(r, cv, cd, sr);
      advance();
   endtask

   initial begin
      logic [N*W-1:0] c;
      tbl[0] = '{32'h0000_0180, 2, 1};
      tbl[1] = '{32'hFFFF_FE80, -1, -2};
      tbl[2] = '{32'h7FFF_FF00, 32767, -1};
      tbl[3] = '{32'h0000_0000, 0, 0};
      tbl[4] = '{32'h0000_0080, 1, 0};
      tbl[5] = '{32'hFFFF_FF80, 0, -1};
      tbl[6] = '{32'h8000_0000, -32768, 0};
      tbl[7] = '{32'h0001_2345, 291, 291};

      rst = 1'b1; col_valid = 1'b0; s_ready = 1'b0; col_data = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state; col_valid during reset must not capture
      drive_check(1'b1, 1'b1, rand_col(), 1'b1);
      chk("rst_sdata0", longint'($signed(if0.s_data)), 0);
      chk("rst_sdata8", longint'($signed(if8.s_data)), 0);
      advance();
      cyc(1'b1, 1'b1, rand_col(), 1'b1);

      // Single column 10..17, captured on the first cycle after release
      for (int k = 0; k < N; k++) c[k*W +: W] = W'(10 + k);
      nwords = 0; nblk = 0;
      cyc(1'b0, 1'b1, c, 1'b1);
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, rand_col(), 1'b1);
      chk("single_words", nwords, 8);

      // Eight back-to-back columns form one contiguous block
      cyc(1'b1, 1'b0, '0, 1'b1);
      nwords = 0; nblk = 0; blk_word = 0;
      for (int k = 0; k < 64; k++) cyc(1'b0, (k % 8) == 0, rand_col(), 1'b1);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, rand_col(), 1'b1);
      chk("b2b_words", nwords, 64);
      chk("b2b_blk_cnt", nblk, 1);
      chk("b2b_blk_word", blk_word, 64);
      cyc(1'b0, 1'b1, rand_col(), 1'b1);
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, rand_col(), 1'b1);
      chk("wrap_blk_cnt", nblk, 1);

      // Backpressure at element 3 for 5 cycles with a column waiting
      cyc(1'b1, 1'b0, '0, 1'b1);
      nwords = 0;
      cyc(1'b0, 1'b1, c, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, rand_col(), 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, rand_col(), 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, rand_col(), 1'b1);
      chk("bp_words", nwords, 8);

      // Reset at word 4 of column 2, then a full fresh block
      cyc(1'b1, 1'b0, '0, 1'b1);
      for (int k = 0; k < 21; k++) cyc(1'b0, (k % 8) == 0, rand_col(), 1'b1);
      cyc(1'b1, 1'b1, rand_col(), 1'b1);
      cyc(1'b1, 1'b1, rand_col(), 1'b1);
      nwords = 0; nblk = 0; blk_word = 0;
      for (int k = 0; k < 64; k++) cyc(1'b0, (k % 8) == 0, rand_col(), 1'b1);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, rand_col(), 1'b1);
      chk("rst_blk_cnt", nblk, 1);
      chk("rst_blk_word", blk_word, 64);

      // Table of rounding/saturation vectors streamed as one column
      cyc(1'b1, 1'b0, '0, 1'b1);
      for (int k = 0; k < N; k++) c[k*W +: W] = tbl[k].din;
      cyc(1'b0, 1'b1, c, 1'b1);
      for (int i = 0; i < N; i++) begin
         drive_check(1'b0, 1'b0, '0, 1'b1);
`ifdef DCT_COLSTREAM_ROUND_EN
         chk($sformatf("tbl8_%0d", i), longint'($signed(if8.s_data)), tbl[i].exp_rnd);
`else
         chk($sformatf("tbl8_%0d", i), longint'($signed(if8.s_data)), tbl[i].exp_flr);
`endif
         chk($sformatf("tbl0_%0d", i), longint'($signed(if0.s_data)),
             longint'($signed(tbl[i].din)));
         advance();
      end

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), rand_col(),
             $urandom_range(0, 3) != 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
